// File: rtl/lmsm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer_if
//   Bundles the request, memory and register-file signals of the load-multiple /
//   store-multiple sequencer so they can be passed as a single port.
//
//   Signals
//     start      : one-cycle request to begin an LM/SM (requester -> sequencer)
//     is_store   : 1 = store-multiple, 0 = load-multiple (sampled with start)
//     mask       : register-select bitmap, bit i selects R[i] (sampled with start)
//     base_addr  : first memory address (sampled with start)
//     mem_ready  : memory completes the current access this cycle
//     busy       : sequencer is not idle
//     reg_addr   : register-file index of the current transfer
//     mem_addr   : memory address of the current transfer
//     mem_read   : memory read request (LM)
//     mem_write  : memory write request (SM)
//     rf_wen     : register-file write strobe for LM data
//     done       : one-cycle completion pulse
//
//   Modports
//     master : requester / memory side (drives start, operands, mem_ready)
//     slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              is_store;
  logic [7:0]        mask;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;
  logic              busy;
  logic [2:0]        reg_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic              rf_wen;
  logic              done;

  modport master (
    output start,
    output is_store,
    output mask,
    output base_addr,
    output mem_ready,
    input  busy,
    input  reg_addr,
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  rf_wen,
    input  done
  );

  modport slave (
    input  start,
    input  is_store,
    input  mask,
    input  base_addr,
    input  mem_ready,
    output busy,
    output reg_addr,
    output mem_addr,
    output mem_read,
    output mem_write,
    output rf_wen,
    output done
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
//   Walks the register-select mask of a load-multiple / store-multiple
//   instruction, issuing one memory access per selected register at
//   consecutive addresses, lowest register index first. Unselected registers
//   are skipped without costing a cycle. mem_ready=0 stalls the current
//   transfer with every output held.
//
//   Ports
//     clk       : single clock, all state changes on its rising edge
//     proc_rst  : asynchronous, active-high reset
//     bus       : lmsm_sequencer_if.slave (request, memory, register-file I/O)
//     wb_en     : (LMSM_WRITEBACK_EN only) base-register writeback strobe,
//                 pulses together with done
//     wb_addr   : (LMSM_WRITEBACK_EN only) base_addr + popcount(mask),
//                 modulo 2^ADDR_W
//
//   Configuration
//     LMSM_WRITEBACK_EN : when defined, adds the wb_en / wb_addr outputs.
//                         When undefined those ports do not exist and the
//                         rest of the behaviour is unchanged.
// -----------------------------------------------------------------------------
module lmsm_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              proc_rst,
  lmsm_sequencer_if.slave   bus
`ifdef LMSM_WRITEBACK_EN
  ,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Index of the lowest set bit; bit 0 has the highest priority.
  // An all-zero mask yields 0.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Remove the lowest set bit (the register just serviced).
  function automatic logic [7:0] clear_lowest(input logic [7:0] m);
    return m & (m - 8'd1);
  endfunction

  state_t            state;
  state_t            state_nxt;

  // Latched operands. mask_p0 holds the registers still to be transferred and
  // addr_p0 the address of the next transfer; after the last transfer addr_p0
  // has advanced by popcount(mask), which is exactly the writeback value.
  logic [7:0]        mask_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              store_p0;

  logic              load;
  logic              advance;

  logic              busy_c;
  logic [2:0]        reg_addr_c;
  logic              mem_read_c;
  logic              mem_write_c;
  logic              rf_wen_c;
  logic              done_c;

  // ---------------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state    <= IDLE;
      mask_p0  <= 8'd0;
      addr_p0  <= '0;
      store_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mask_p0  <= bus.mask;
        addr_p0  <= bus.base_addr;
        store_p0 <= bus.is_store;
      end else if (advance) begin
        mask_p0  <= clear_lowest(mask_p0);
        addr_p0  <= addr_p0 + ADDR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    advance     = 1'b0;
    busy_c      = 1'b0;
    reg_addr_c  = 3'd0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    rf_wen_c    = 1'b0;
    done_c      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
          // An empty mask still produces a single DONE cycle.
          state_nxt = (bus.mask == 8'd0) ? DONE : ACCESS;
        end
      end

      ACCESS: begin
        busy_c      = 1'b1;
        reg_addr_c  = lowest_set(mask_p0);
        mem_read_c  = ~store_p0;
        mem_write_c = store_p0;
        if (bus.mem_ready) begin
          advance  = 1'b1;
          // Load data is on the bus in the completing cycle only.
          rf_wen_c = ~store_p0;
          if (clear_lowest(mask_p0) == 8'd0) begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_c;
  assign bus.reg_addr  = reg_addr_c;
  assign bus.mem_addr  = addr_p0;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.rf_wen    = rf_wen_c;
  assign bus.done      = done_c;

`ifdef LMSM_WRITEBACK_EN
  assign wb_en   = done_c;
  assign wb_addr = addr_p0;
`endif

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port proc_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load-multiple/store-multiple, sampled only in IDLE.
REQ-005 SHALL have port is_store  input  1  1 = store-multiple (SM), 0 = load-multiple (LM), sampled with start.
REQ-006 SHALL have port mask  input  8  register-select bitmap (IR[7:0]); bit i selects R[i]; sampled with start.
REQ-007 SHALL have port base_addr  input  ADDR_W  starting memory address; sampled with start.
REQ-008 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port reg_addr  output  3  register-file index for the current transfer.
REQ-011 SHALL have port mem_addr  output  ADDR_W  memory address for the current transfer.
REQ-012 SHALL have port mem_read  output  1  memory read request (LM).
REQ-013 SHALL have port mem_write  output  1  memory write request (SM).
REQ-014 SHALL have port rf_wen  output  1  register-file write strobe for LM data.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, ACCESS, DONE.
REQ-017 IDLE: on start=1 SHALL latch mask, base_addr, is_store; go to ACCESS if mask!=0, else to DONE.
REQ-018 SHALL ignore start while busy=1; latched operands SHALL NOT change until IDLE.
REQ-019 ACCESS: reg_addr SHALL equal the index of the lowest set bit of the remaining mask (priority: bit 0 highest).
REQ-020 ACCESS: mem_addr SHALL equal the current address register; mem_read = ~is_store, mem_write = is_store, held steady until mem_ready.
REQ-021 ACCESS with mem_ready=1 and LM: rf_wen SHALL be high combinationally in that same cycle only.
REQ-022 ACCESS with mem_ready=1: SHALL clear the serviced mask bit and increment address by 1 (modulo 2^ADDR_W, 16'hFFFF wraps to 16'h0000) at the next edge.
REQ-023 If the cleared mask becomes zero SHALL go to DONE, else stay in ACCESS; unset registers SHALL cost zero cycles.
REQ-024 Each transfer SHALL take 1 cycle minimum; mem_ready=0 SHALL stall with all outputs unchanged.
REQ-025 DONE: done=1 for exactly one cycle, all request strobes 0, then IDLE; start in DONE SHALL be ignored.
REQ-026 mask=0 SHALL yield one DONE cycle with no memory or register-file activity.
REQ-027 Outside ACCESS, mem_read, mem_write, rf_wen SHALL be 0.

Reset
REQ-028 proc_rst=1 SHALL immediately force IDLE, clear latched mask, address register to 0, busy/mem_read/mem_write/rf_wen/done to 0, reg_addr to 0.
REQ-029 Reset asserted mid-ACCESS SHALL abort the transfer with no rf_wen pulse and no done pulse.

Configuration
REQ-030 Macro LMSM_WRITEBACK_EN defined: SHALL add outputs wb_en (1) and wb_addr (ADDR_W); wb_en pulses with done, wb_addr = base_addr + popcount(mask) modulo 2^ADDR_W.
REQ-031 Macro LMSM_WRITEBACK_EN undefined: wb_en/wb_addr ports SHALL NOT exist; all other behaviour identical.

Verification
REQ-032 LM mask=8'b1000_0101, base=16'h0040, mem_ready=1 -> reg_addr 0,2,7 at mem_addr 0040,0041,0042; 3 rf_wen pulses; done 1 cycle later; wb_addr=16'h0043 when enabled.
REQ-033 SM mask=8'hFF, base=16'hFFFE -> mem_write 8 cycles, addresses FFFE,FFFF,0000..0005 (wrap), reg_addr 0..7, rf_wen never high.
REQ-034 mask=8'h00 with start -> busy 1 cycle, done pulse, no mem_read/mem_write/rf_wen.
REQ-035 LM mask=8'h12, mem_ready low 3 cycles on first access -> reg_addr=1, mem_addr=base held, single rf_wen when ready rises, then reg_addr=4.
REQ-036 proc_rst pulsed during second transfer of mask=8'h0F -> outputs 0 asynchronously, IDLE, no done; fresh start then completes normally.
REQ-037 start re-asserted while busy -> ignored; latched mask/base unchanged, transfer count matches original mask.
